// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared widths, types and constants for the swt16 register file and its
// pending-write scoreboard.
// -----------------------------------------------------------------------------
package register_file_pkg;

  localparam int IALU_WORD_WIDTH = 16;
  localparam int REG_IDX_WIDTH   = 4;
  localparam int REG_COUNT       = 2 ** REG_IDX_WIDTH;
  localparam int SB_CNT_WIDTH    = 2;

  typedef logic [IALU_WORD_WIDTH-1:0] word_t;
  typedef logic [REG_IDX_WIDTH-1:0]   idx_t;
  typedef logic [SB_CNT_WIDTH-1:0]    cnt_t;
  typedef logic [REG_COUNT-1:0]       reg_mask_t;

  localparam cnt_t      SB_CNT_ZERO = {SB_CNT_WIDTH{1'b0}};
  localparam cnt_t      SB_CNT_ONE  = {{(SB_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam cnt_t      SB_CNT_MAX  = {SB_CNT_WIDTH{1'b1}};
  localparam reg_mask_t REG_MASK_0  = {{(REG_COUNT-1){1'b0}}, 1'b1};
  localparam word_t     WORD_ZERO   = {IALU_WORD_WIDTH{1'b0}};

  // A register is busy when pending writes remain after accounting for a
  // write landing this very cycle (which is forwarded by the bypass mux).
  function automatic logic eff_busy(input cnt_t cnt, input logic wr_hit);
    return (cnt > SB_CNT_ONE) || ((cnt == SB_CNT_ONE) && !wr_hit);
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Per-register pending-write counters. Claims from decode increment, writes
// from writeback decrement; overflow/underflow set a sticky error.
// Ports:
//   clock, reset          - clock and async active-high reset
//   wr_en_i, wr_idx_i     - writeback write strobe and destination
//   claim_en_i, claim_idx_i - decode claim strobe and destination
//   rd_idx_a_i/b_i        - read port indices for busy lookup
//   busy_a_o/b_o          - pending write not yet visible on that index
//   claim_full_o          - claimed register counter already saturated
//   sb_error_o            - sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module reg_scoreboard
  import register_file_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic wr_en_i,
  input  idx_t wr_idx_i,
  input  logic claim_en_i,
  input  idx_t claim_idx_i,
  input  idx_t rd_idx_a_i,
  input  idx_t rd_idx_b_i,
  output logic busy_a_o,
  output logic busy_b_o,
  output logic claim_full_o,
  output logic sb_error_o
);

  cnt_t      cnt_q [REG_COUNT];
  cnt_t      cnt_d [REG_COUNT];
  logic      err_q;
  logic      err_d;
  reg_mask_t claim_dec_s;
  reg_mask_t wr_dec_s;

  // One-hot decode of the claim and write destinations.
  always_comb begin
    claim_dec_s = {REG_COUNT{1'b0}};
    wr_dec_s    = {REG_COUNT{1'b0}};
    if (claim_en_i) begin
      claim_dec_s = REG_MASK_0 << claim_idx_i;
    end else begin
      claim_dec_s = {REG_COUNT{1'b0}};
    end
    if (wr_en_i) begin
      wr_dec_s = REG_MASK_0 << wr_idx_i;
    end else begin
      wr_dec_s = {REG_COUNT{1'b0}};
    end
  end

  // Next counter values; a claim and write to the same register cancel out.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < REG_COUNT; r++) begin
      cnt_d[r] = cnt_q[r];
      case ({claim_dec_s[r], wr_dec_s[r]})
        2'b10: begin
          if (cnt_q[r] == SB_CNT_MAX) begin
            err_d = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] + SB_CNT_ONE;
          end
        end
        2'b01: begin
          // Unclaimed write-back still lands in the file; only flag it.
          if (cnt_q[r] == SB_CNT_ZERO) begin
            err_d = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] - SB_CNT_ONE;
          end
        end
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  // Counter and sticky error state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= SB_CNT_ZERO;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  // Hazard and capacity flags seen by decode.
  always_comb begin
    busy_a_o     = eff_busy(cnt_q[rd_idx_a_i], wr_dec_s[rd_idx_a_i]);
    busy_b_o     = eff_busy(cnt_q[rd_idx_b_i], wr_dec_s[rd_idx_b_i]);
    claim_full_o = claim_en_i && (cnt_q[claim_idx_i] == SB_CNT_MAX);
    sb_error_o   = err_q;
  end

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// swt16 architectural register file: one write port from writeback, two
// combinational read ports with write-through bypass, and a pending-write
// scoreboard for RAW stall detection in decode.
// Ports:
//   clock, reset                        - clock, async active-high reset
//   in_act_write_res_to_reg, in_res,
//   in_res_reg_idx                      - writeback write port
//   in_rd_idx_a/b, out_rd_data_a/b      - read ports (zero latency)
//   out_busy_a/b                        - read register has an unseen write
//   in_act_claim_reg, in_claim_reg_idx  - decode destination claim
//   out_claim_full                      - claimed counter saturated
//   out_sb_error                        - sticky scoreboard error
// -----------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  in_act_write_res_to_reg,
  input  word_t in_res,
  input  idx_t  in_res_reg_idx,
  input  idx_t  in_rd_idx_a,
  input  idx_t  in_rd_idx_b,
  output word_t out_rd_data_a,
  output word_t out_rd_data_b,
  output logic  out_busy_a,
  output logic  out_busy_b,
  input  logic  in_act_claim_reg,
  input  idx_t  in_claim_reg_idx,
  output logic  out_claim_full,
  output logic  out_sb_error
);

  word_t mem_q [REG_COUNT];

  // Storage array; index 0 is an ordinary writable register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        mem_q[r] <= WORD_ZERO;
      end
    end else if (in_act_write_res_to_reg) begin
      mem_q[in_res_reg_idx] <= in_res;
    end
  end

  // Read muxes with write-through bypass; forced to zero while in reset.
  always_comb begin
    out_rd_data_a = mem_q[in_rd_idx_a];
    out_rd_data_b = mem_q[in_rd_idx_b];
    if (reset) begin
      out_rd_data_a = WORD_ZERO;
    end else if (in_act_write_res_to_reg && (in_res_reg_idx == in_rd_idx_a)) begin
      out_rd_data_a = in_res;
    end else begin
      out_rd_data_a = mem_q[in_rd_idx_a];
    end
    if (reset) begin
      out_rd_data_b = WORD_ZERO;
    end else if (in_act_write_res_to_reg && (in_res_reg_idx == in_rd_idx_b)) begin
      out_rd_data_b = in_res;
    end else begin
      out_rd_data_b = mem_q[in_rd_idx_b];
    end
  end

  reg_scoreboard u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .wr_en_i      (in_act_write_res_to_reg),
    .wr_idx_i     (in_res_reg_idx),
    .claim_en_i   (in_act_claim_reg),
    .claim_idx_i  (in_claim_reg_idx),
    .rd_idx_a_i   (in_rd_idx_a),
    .rd_idx_b_i   (in_rd_idx_b),
    .busy_a_o     (out_busy_a),
    .busy_b_o     (out_busy_b),
    .claim_full_o (out_claim_full),
    .sb_error_o   (out_sb_error)
  );

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Self-checking bench: a reference model of the file and scoreboard produces
// expected outputs that are queued when stimulus is applied and compared
// against the DUT shortly before the next rising edge.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic        clock;
  logic        reset;
  logic        in_act_write_res_to_reg;
  logic [15:0] in_res;
  logic [3:0]  in_res_reg_idx;
  logic [3:0]  in_rd_idx_a;
  logic [3:0]  in_rd_idx_b;
  logic [15:0] out_rd_data_a;
  logic [15:0] out_rd_data_b;
  logic        out_busy_a;
  logic        out_busy_b;
  logic        in_act_claim_reg;
  logic [3:0]  in_claim_reg_idx;
  logic        out_claim_full;
  logic        out_sb_error;

  register_file dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_act_write_res_to_reg (in_act_write_res_to_reg),
    .in_res                  (in_res),
    .in_res_reg_idx          (in_res_reg_idx),
    .in_rd_idx_a             (in_rd_idx_a),
    .in_rd_idx_b             (in_rd_idx_b),
    .out_rd_data_a           (out_rd_data_a),
    .out_rd_data_b           (out_rd_data_b),
    .out_busy_a              (out_busy_a),
    .out_busy_b              (out_busy_b),
    .in_act_claim_reg        (in_act_claim_reg),
    .in_claim_reg_idx        (in_claim_reg_idx),
    .out_claim_full          (out_claim_full),
    .out_sb_error            (out_sb_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model state
  logic [15:0] m_mem [16];
  int          m_cnt [16];
  bit          m_err;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      0: return out_rd_data_a;
      1: return out_rd_data_b;
      2: return {15'd0, out_busy_a};
      3: return {15'd0, out_busy_b};
      4: return {15'd0, out_claim_full};
      5: return {15'd0, out_sb_error};
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  function automatic logic [15:0] m_data(input logic [3:0] idx);
    if (in_act_write_res_to_reg && in_res_reg_idx == idx) return in_res;
    return m_mem[idx];
  endfunction

  function automatic logic m_busy(input logic [3:0] idx);
    int e;
    e = m_cnt[idx] - ((in_act_write_res_to_reg && in_res_reg_idx == idx) ? 1 : 0);
    if (e < 0) e = 0;
    return e != 0;
  endfunction

  task automatic push_all(input string tag);
    push_exp({tag, ".da"}, 0, m_data(in_rd_idx_a));
    push_exp({tag, ".db"}, 1, m_data(in_rd_idx_b));
    push_exp({tag, ".ba"}, 2, {15'd0, m_busy(in_rd_idx_a)});
    push_exp({tag, ".bb"}, 3, {15'd0, m_busy(in_rd_idx_b)});
    push_exp({tag, ".full"}, 4,
             {15'd0, in_act_claim_reg && (m_cnt[in_claim_reg_idx] == 3)});
    push_exp({tag, ".err"}, 5, {15'd0, m_err});
  endtask

  task automatic model_update();
    for (int r = 0; r < 16; r++) begin
      bit ch, wh;
      ch = in_act_claim_reg && (in_claim_reg_idx == r[3:0]);
      wh = in_act_write_res_to_reg && (in_res_reg_idx == r[3:0]);
      if (ch && !wh) begin
        if (m_cnt[r] == 3) m_err = 1'b1;
        else m_cnt[r]++;
      end else if (wh && !ch) begin
        if (m_cnt[r] == 0) m_err = 1'b1;
        else m_cnt[r]--;
      end
    end
    if (in_act_write_res_to_reg) m_mem[in_res_reg_idx] = in_res;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 16; r++) begin
      m_mem[r] = 16'h0000;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endtask

  // Called at a falling edge; applies one cycle of stimulus.
  task automatic step(input string tag, input logic w, input logic [3:0] widx,
                      input logic [15:0] res, input logic c, input logic [3:0] cidx,
                      input logic [3:0] ra, input logic [3:0] rb);
    in_act_write_res_to_reg = w;
    in_res_reg_idx          = widx;
    in_res                  = res;
    in_act_claim_reg        = c;
    in_claim_reg_idx        = cidx;
    in_rd_idx_a             = ra;
    in_rd_idx_b             = rb;
    push_all(tag);
    #2;
    drain();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    in_act_write_res_to_reg = 1'b0;
    in_res_reg_idx          = 4'd0;
    in_res                  = 16'h0000;
    in_act_claim_reg        = 1'b0;
    in_claim_reg_idx        = 4'd0;
  endtask

  // Called at a falling edge; pulses reset and checks the cleared state.
  task automatic do_reset(input string tag, input logic [3:0] ra);
    idle_inputs();
    in_rd_idx_a = ra;
    in_rd_idx_b = ra;
    reset = 1'b1;
    #2;
    push_exp({tag, ".da"}, 0, 16'h0000);
    push_exp({tag, ".db"}, 1, 16'h0000);
    push_exp({tag, ".ba"}, 2, 16'h0000);
    push_exp({tag, ".err"}, 5, 16'h0000);
    drain();
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    in_rd_idx_a = 4'd0;
    in_rd_idx_b = 4'd0;
    model_clear();
    @(negedge clock);

    // Reset state on every index, both ports
    for (int i = 0; i < 16; i++) begin
      in_rd_idx_a = i[3:0];
      in_rd_idx_b = 4'(15 - i);
      #1;
      push_exp("rst.da", 0, 16'h0000);
      push_exp("rst.db", 1, 16'h0000);
      push_exp("rst.ba", 2, 16'h0000);
      push_exp("rst.bb", 3, 16'h0000);
      push_exp("rst.full", 4, 16'h0000);
      push_exp("rst.err", 5, 16'h0000);
      drain();
    end
    @(negedge clock);
    reset = 1'b0;

    // Plain write then read
    step("wr_r5", 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd0, 4'd0);
    step("rd_r5", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd5);
    // Write-through bypass on both ports
    step("byp_r7", 1'b1, 4'd7, 16'h1234, 1'b0, 4'd0, 4'd7, 4'd7);
    // Claim, observe busy, then write clears busy in the write cycle
    step("clm_r3", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd3, 4'd0);
    step("busy1_r3", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd0);
    step("busy2_r3", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd0);
    step("wr_r3", 1'b1, 4'd3, 16'h00AA, 1'b0, 4'd0, 4'd3, 4'd3);
    // Saturate r9 then overflow
    for (int k = 0; k < 3; k++) begin
      step("clm_r9", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 4'd9, 4'd9);
    end
    step("ovf_r9", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 4'd9, 4'd9);
    step("post_ovf", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd9);
    // Three writes drain r9; busy drops only on the third
    step("drn9_1", 1'b1, 4'd9, 16'h0901, 1'b0, 4'd0, 4'd9, 4'd9);
    step("drn9_2", 1'b1, 4'd9, 16'h0902, 1'b0, 4'd0, 4'd9, 4'd9);
    step("drn9_3", 1'b1, 4'd9, 16'h0903, 1'b0, 4'd0, 4'd9, 4'd9);
    // Same-cycle claim and write on r2 leaves its count unchanged
    step("clm_r2", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd2, 4'd2);
    step("cw_r2", 1'b1, 4'd2, 16'h5555, 1'b1, 4'd2, 4'd2, 4'd2);
    step("aft_r2", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd2);
    // Claim and write on different registers
    step("cw_diff", 1'b1, 4'd2, 16'h2222, 1'b1, 4'd6, 4'd2, 4'd6);
    step("aft_diff", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd6);

    // Underflow on an unclaimed write, then reset clears everything
    do_reset("rst2", 4'd6);
    step("uf_r4", 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 4'd4, 4'd0);
    step("aft_uf", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd4);
    do_reset("rst3", 4'd4);
    step("aft_rst3", 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd0);

    // Random traffic against the model
    for (int k = 0; k < 80; k++) begin
      step("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
